// File: rtl/node_port_if.sv
// Node-side endpoint for one router port: TX FIFO plus 32-to-8 serializer, RX 8-to-32 deserializer with holding register.
// Optional NODE_PORT_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module node_port_if #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pkt_in_valid,
    input  logic [31:0] pkt_in,
    output logic        pkt_in_ready,
    input  logic        router_free,
    output logic        node_put,
    output logic [7:0]  node_payload,
    input  logic        router_put,
    input  logic [7:0]  router_payload,
    output logic        node_free,
    output logic        pkt_out_valid,
    output logic [31:0] pkt_out,
    input  logic        pkt_out_ready
`ifdef NODE_PORT_PROTOCOL_CHECK_EN
    ,
    output logic        proto_err
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        SEND
    } tx_state_t;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          empty;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [1:0]    c;
    logic [1:0]    c_next;
    logic [23:0]   shift_reg;
    logic [23:0]   shift_next;
    logic          put_next;
    logic [7:0]    payload_next;

    logic [1:0]    r;
    logic [1:0]    r_next;
    logic [23:0]   rx_shift;
    logic          accept;
    logic          consume;
    logic          complete;
    logic          valid_next;

    assign pkt_in_ready = (count != FULL_COUNT);
    assign empty        = (count == '0);
    assign push         = pkt_in_valid && pkt_in_ready;

    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= pkt_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Shift register keeps only the bytes still to be sent; the MSB byte goes straight to the payload on load.
    always_comb begin
        state_next   = state;
        c_next       = c;
        shift_next   = shift_reg;
        put_next     = node_put;
        payload_next = node_payload;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && router_free) begin
                    pop          = 1'b1;
                    state_next   = SEND;
                    c_next       = 2'd0;
                    shift_next   = mem[rd_ptr][23:0];
                    put_next     = 1'b1;
                    payload_next = mem[rd_ptr][31:24];
                end
            end
            SEND: begin
                if (c == 2'd3) begin
                    state_next   = IDLE;
                    c_next       = 2'd0;
                    put_next     = 1'b0;
                    payload_next = 8'h00;
                end else begin
                    c_next       = c + 2'd1;
                    shift_next   = {shift_reg[15:0], 8'h00};
                    payload_next = shift_reg[23:16];
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            c            <= 2'd0;
            shift_reg    <= '0;
            node_put     <= 1'b0;
            node_payload <= 8'h00;
        end else begin
            state        <= state_next;
            c            <= c_next;
            shift_reg    <= shift_next;
            node_put     <= put_next;
            node_payload <= payload_next;
        end
    end

    // Bytes arriving while a word is held are dropped, so accept gates every RX state change.
    assign accept     = router_put && !pkt_out_valid;
    assign consume    = pkt_out_valid && pkt_out_ready;
    assign complete   = accept && (r == 2'd3);
    assign r_next     = accept ? r + 2'd1 : r;
    assign valid_next = complete || (pkt_out_valid && !consume);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r             <= 2'd0;
            rx_shift      <= '0;
            pkt_out_valid <= 1'b0;
            pkt_out       <= '0;
            node_free     <= 1'b1;
        end else begin
            r             <= r_next;
            pkt_out_valid <= valid_next;
            node_free     <= (r_next == 2'd0) && !valid_next;
            if (complete) begin
                pkt_out <= {rx_shift, router_payload};
            end else if (accept) begin
                rx_shift <= {rx_shift[15:0], router_payload};
            end
        end
    end

`ifdef NODE_PORT_PROTOCOL_CHECK_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            proto_err <= 1'b0;
        end else if (router_put && (pkt_out_valid || (!node_free && r == 2'd0))) begin
            proto_err <= 1'b1;
        end
    end
`endif

endmodule
